// File: rtl/kbd_cursor_pkg.sv
// Shared constants for the keyboard-driven cursor controller: key codes,
// FSM state encoding and cursor/colour widths.
package kbd_cursor_pkg;

  localparam int CODE_W = 6;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int COL_W  = 3;

  localparam logic [CODE_W-1:0] KEY_NONE      = 6'd0;
  localparam logic [CODE_W-1:0] KEY_UP        = 6'd1;
  localparam logic [CODE_W-1:0] KEY_DOWN      = 6'd2;
  localparam logic [CODE_W-1:0] KEY_LEFT      = 6'd3;
  localparam logic [CODE_W-1:0] KEY_RIGHT     = 6'd4;
  localparam logic [CODE_W-1:0] KEY_HOME      = 6'd5;
  localparam logic [CODE_W-1:0] KEY_COL_FIRST = 6'd6;
  localparam logic [CODE_W-1:0] KEY_COL_LAST  = 6'd13;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_POP        = 2'd1,
    ST_WAIT_FRAME = 2'd2,
    ST_APPLY      = 2'd3
  } state_e;

endpackage

// File: rtl/kbd_code_fifo.sv
// Small synchronous key-code FIFO with a registered occupancy count and a
// first-word-fall-through head (dout is valid whenever empty is low).
module kbd_code_fifo
  import kbd_cursor_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [CODE_W-1:0] din,
  output logic [CODE_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when a pop frees the head slot
  // in the same cycle; otherwise the code is dropped.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/kbd_cursor_ctrl.sv
// Keyboard code consumer: edge-detects key codes, queues them, and applies one
// cursor/colour command per video frame. Define WRAP_EN for wrap-around edges.
module kbd_cursor_ctrl
  import kbd_cursor_pkg::*;
#(
  parameter int COLS       = 640,
  parameter int ROWS       = 480,
  parameter int STEP       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CODE_W-1:0] ps2OutCode,
  input  logic              frameTick,
  output logic [X_W-1:0]    cursorX,
  output logic [Y_W-1:0]    cursorY,
  output logic [COL_W-1:0]  drawColour,
  output logic              cmdPending,
  output logic              overflow
);

  // Both axes share one arithmetic width, one bit wider than X.
  localparam int AXW = X_W + 1;
  localparam logic [AXW-1:0] STEP_A = AXW'(STEP);
  localparam logic [AXW-1:0] COLS_A = AXW'(COLS);
  localparam logic [AXW-1:0] ROWS_A = AXW'(ROWS);
  localparam logic [X_W-1:0] X_HOME = X_W'(COLS / 2);
  localparam logic [Y_W-1:0] Y_HOME = Y_W'(ROWS / 2);

`ifdef WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  function automatic logic [AXW-1:0] move_dec(input logic [AXW-1:0] v,
                                               input logic [AXW-1:0] lim);
    logic [AXW-1:0] wrapv;
    wrapv = (v + lim) - STEP_A;
    if (v < STEP_A) move_dec = WRAP ? wrapv : '0;
    else            move_dec = v - STEP_A;
  endfunction

  function automatic logic [AXW-1:0] move_inc(input logic [AXW-1:0] v,
                                               input logic [AXW-1:0] lim);
    logic [AXW-1:0] wrapv;
    wrapv = (v + STEP_A) - lim;
    if (v > lim - AXW'(1) - STEP_A) move_inc = WRAP ? wrapv : lim - AXW'(1);
    else                            move_inc = v + STEP_A;
  endfunction

  logic [CODE_W-1:0] prev_code_q;
  logic [CODE_W-1:0] cmd_q;
  logic [CODE_W-1:0] fifo_dout;
  logic              new_key, fifo_pop, fifo_full, fifo_empty;
  state_e            state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              ovf_q;

  assign new_key  = (ps2OutCode != prev_code_q) && (ps2OutCode != KEY_NONE);
  assign fifo_pop = (state_q == ST_POP);

  kbd_code_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (new_key),
    .pop   (fifo_pop),
    .din   (ps2OutCode),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_code_q <= KEY_NONE;
      ovf_q       <= 1'b0;
    end else begin
      prev_code_q <= ps2OutCode;
      if (new_key && fifo_full && !fifo_pop) ovf_q <= 1'b1;
    end
  end

  // ---- command FSM ----
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (!fifo_empty) state_d = ST_POP;
      ST_POP:        state_d = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (frameTick) state_d = ST_APPLY;
      ST_APPLY:      state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (state_q == ST_POP) cmd_q <= fifo_dout;
  end

  // ---- cursor / colour datapath ----
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    col_d = col_q;
    case (cmd_q)
      KEY_UP:    y_d = Y_W'(move_dec({{(AXW-Y_W){1'b0}}, y_q}, ROWS_A));
      KEY_DOWN:  y_d = Y_W'(move_inc({{(AXW-Y_W){1'b0}}, y_q}, ROWS_A));
      KEY_LEFT:  x_d = X_W'(move_dec({{(AXW-X_W){1'b0}}, x_q}, COLS_A));
      KEY_RIGHT: x_d = X_W'(move_inc({{(AXW-X_W){1'b0}}, x_q}, COLS_A));
      KEY_HOME: begin
        x_d = X_HOME;
        y_d = Y_HOME;
      end
      default: begin
        // code-6 modulo 8 equals the low three bits plus 2.
        if (cmd_q >= KEY_COL_FIRST && cmd_q <= KEY_COL_LAST)
          col_d = cmd_q[COL_W-1:0] + COL_W'(2);
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q   <= X_HOME;
      y_q   <= Y_HOME;
      col_q <= '1;
    end else if (state_q == ST_APPLY) begin
      x_q   <= x_d;
      y_q   <= y_d;
      col_q <= col_d;
    end
  end

  assign cursorX    = x_q;
  assign cursorY    = y_q;
  assign drawColour = col_q;
  assign cmdPending = !fifo_empty || (state_q != ST_IDLE);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_kbd_cursor_ctrl.sv
// Scoreboard bench for kbd_cursor_ctrl: expected cursor state is queued per
// accepted key press and compared after each frame that applies a command.
module tb_kbd_cursor_ctrl;

  localparam int COLS = 640;
  localparam int ROWS = 480;
  localparam int STEP = 8;
  localparam int CAP  = 5;  // FIFO depth plus the command held in flight

`ifdef WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct packed {
    int x;
    int y;
    int c;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] ps2OutCode = '0;
  logic       frameTick = 1'b0;
  logic [9:0] cursorX;
  logic [8:0] cursorY;
  logic [2:0] drawColour;
  logic       cmdPending;
  logic       overflow;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t last_e;
  int   mx, my, mc;
  bit   movf;

  always #5 clock = ~clock;

  kbd_cursor_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .STEP(STEP), .FIFO_DEPTH(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ps2OutCode (ps2OutCode),
    .frameTick  (frameTick),
    .cursorX    (cursorX),
    .cursorY    (cursorY),
    .drawColour (drawColour),
    .cmdPending (cmdPending),
    .overflow   (overflow)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic model_reset();
    exp_q.delete();
    mx = COLS / 2; my = ROWS / 2; mc = 7; movf = 1'b0;
    last_e = '{x: mx, y: my, c: mc};
  endtask

  function automatic void model_apply(input int code);
    int n;
    case (code)
      1: begin n = my - STEP; if (n < 0) n = WRAP ? n + ROWS : 0; my = n; end
      2: begin n = my + STEP; if (n > ROWS - 1) n = WRAP ? n - ROWS : ROWS - 1; my = n; end
      3: begin n = mx - STEP; if (n < 0) n = WRAP ? n + COLS : 0; mx = n; end
      4: begin n = mx + STEP; if (n > COLS - 1) n = WRAP ? n - COLS : COLS - 1; mx = n; end
      5: begin mx = COLS / 2; my = ROWS / 2; end
      default: if (code >= 6 && code <= 13) mc = code - 6;
    endcase
  endfunction

  task automatic model_push(input int code);
    if (exp_q.size() >= CAP) begin
      movf = 1'b1;
    end else begin
      model_apply(code);
      exp_q.push_back('{x: mx, y: my, c: mc});
    end
  endtask

  task automatic press(input int code);
    ps2OutCode = 6'(code);
    model_push(code);
    cyc(2);
    ps2OutCode = '0;
    cyc(2);
  endtask

  task automatic frame(input string tag);
    exp_t e;
    cyc(1);
    frameTick = 1'b1;
    cyc(1);
    frameTick = 1'b0;
    cyc(5);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_e = e;
    end else begin
      e = last_e;
    end
    check_eq({tag, ".x"}, int'(cursorX), e.x);
    check_eq({tag, ".y"}, int'(cursorY), e.y);
    check_eq({tag, ".col"}, int'(drawColour), e.c);
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, ".pending"}, int'(cmdPending), (exp_q.size() > 0) ? 1 : 0);
    check_eq({tag, ".overflow"}, int'(overflow), int'(movf));
  endtask

  initial begin
    model_reset();
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check_eq("rst.x", int'(cursorX), 320);
    check_eq("rst.y", int'(cursorY), 240);
    check_eq("rst.col", int'(drawColour), 7);
    check_status("rst");

    // single right move
    press(4);
    check_status("right1");
    frame("right1");
    check_status("right1_done");

    // held key moves once; release and re-press moves again
    ps2OutCode = 6'd4;
    model_push(4);
    cyc(2);
    frame("hold_f1");
    frame("hold_f2");
    frame("hold_f3");
    ps2OutCode = '0;
    cyc(2);
    press(4);
    frame("repress");

    // overflow: one in flight, four queued, sixth dropped
    press(1); press(2); press(3); press(4); press(1); press(2);
    check_status("ovf");
    for (int i = 0; i < 6; i++) frame($sformatf("ovf_f%0d", i));
    check_status("ovf_drained");

    // colour codes and an ignored code
    press(9);  frame("col9");
    press(13); frame("col13");
    press(6);  frame("col6");
    press(50); frame("ign50");
    check_status("ign50");

    // walk into each edge and one step past it
    press(5); frame("home1");
    for (int i = 0; i < 41; i++) begin press(3); frame($sformatf("left%0d", i)); end
    press(5); frame("home2");
    for (int i = 0; i < 41; i++) begin press(4); frame($sformatf("right%0d", i)); end
    press(5); frame("home3");
    for (int i = 0; i < 31; i++) begin press(1); frame($sformatf("up%0d", i)); end
    press(5); frame("home4");
    for (int i = 0; i < 31; i++) begin press(2); frame($sformatf("down%0d", i)); end
    check_status("edges");

    // reset while a command waits for its frame with two more queued
    press(4); press(3); press(1);
    check_status("pre_rst");
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    model_reset();
    cyc(1);
    check_eq("midrst.x", int'(cursorX), 320);
    check_eq("midrst.y", int'(cursorY), 240);
    check_eq("midrst.col", int'(drawColour), 7);
    check_status("midrst");
    frame("midrst_tick");
    check_status("midrst_tick");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
